// File: rtl/mat_fx_pkg.sv
// Shared widths, saturation constant and FSM encoding for the fixed-point
// matrix datapath.
package mat_fx_pkg;

  localparam int unsigned BIT_NUM_DEF  = 18;
  localparam int unsigned FRAC_NUM_DEF = 9;
  localparam int unsigned PROD_W       = 2 * BIT_NUM_DEF + 1;
  localparam int unsigned NUM_W        = PROD_W + FRAC_NUM_DEF;

  localparam logic [BIT_NUM_DEF-1:0] SAT_MAX = {1'b0, {(BIT_NUM_DEF-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PROD = 3'd1,
    DIV0 = 3'd2,
    DIV1 = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mat2x2_solve_seq_div.sv
// Unsigned sequential restoring divider: one load/overflow-check cycle,
// then one quotient bit per cycle, MSB first.
module fx_div_restoring
  import mat_fx_pkg::*;
#(
  parameter int unsigned NUM_W_P = NUM_W,
  parameter int unsigned DEN_W   = PROD_W,
  parameter int unsigned Q_W     = BIT_NUM_DEF - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [NUM_W_P-1:0] numerator,
  input  logic [DEN_W-1:0]   denominator,
  output logic               busy,
  output logic               done,
  output logic [Q_W-1:0]     quotient,
  output logic               overflow
);

  localparam int unsigned CW    = $clog2(Q_W + 1);
  localparam int unsigned CMP_W = (NUM_W_P > DEN_W + Q_W) ? NUM_W_P : DEN_W + Q_W;

  logic [DEN_W-1:0] rem, den_r, rem_next;
  logic [Q_W-1:0]   lo, q_r, q_next;
  logic [CW-1:0]    cnt;
  logic             ovf_r;
  logic [DEN_W:0]   trial, diff;
  logic             ge;

  always_comb begin
    trial    = {rem, lo[Q_W-1]};
    diff     = trial - {1'b0, den_r};
    ge       = (trial >= {1'b0, den_r});
    rem_next = DEN_W'(ge ? diff : trial);
    q_next   = Q_W'({q_r, ge});
  end

  assign done     = busy && (cnt == CW'(1));
  assign quotient = q_next;
  assign overflow = ovf_r;

  // Without overflow num >> Q_W < den, so the partial remainder starts in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      den_r <= '0;
      lo    <= '0;
      q_r   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (load) begin
      rem   <= DEN_W'(numerator >> Q_W);
      den_r <= denominator;
      lo    <= numerator[Q_W-1:0];
      q_r   <= '0;
      cnt   <= CW'(Q_W);
      busy  <= 1'b1;
      ovf_r <= CMP_W'(numerator) >= CMP_W'({denominator, {Q_W{1'b0}}});
    end else if (busy) begin
      rem <= rem_next;
      lo  <= lo << 1;
      q_r <= q_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mat2x2_solve_seq.sv
// Solves A*X = C for a 2x2 fixed-point matrix using Cramer's rule with one
// time-shared divider; fixed latency regardless of data.
module mat2x2_solve_seq
  import mat_fx_pkg::*;
#(
  parameter int unsigned BIT_NUM  = BIT_NUM_DEF,
  parameter int unsigned FRAC_NUM = FRAC_NUM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_NUM-1:0] A_00,
  input  logic [BIT_NUM-1:0] A_01,
  input  logic [BIT_NUM-1:0] A_10,
  input  logic [BIT_NUM-1:0] A_11,
  input  logic [BIT_NUM-1:0] C_00,
  input  logic [BIT_NUM-1:0] C_10,
  output logic               out_valid,
  output logic [BIT_NUM-1:0] X_00,
  output logic [BIT_NUM-1:0] X_10,
  output logic               singular
);

  localparam int unsigned PW    = 2 * BIT_NUM + 1;
  localparam int unsigned NW    = PW + FRAC_NUM;
  localparam int unsigned Q_W   = BIT_NUM - 1;
  localparam int unsigned CNT_W = $clog2(BIT_NUM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_NUM - 1);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic signed [BIT_NUM-1:0]  a00, a01, a10, a11, c00, c10, x0;
  logic signed [PW-1:0]       det, n0, n1, det_c, n0_c, n1_c, n_sel;
  logic [NW-1:0]              div_num;
  logic [PW-1:0]              div_den;
  logic [Q_W-1:0]             div_q, q_mag;
  logic                       div_busy, div_done, div_ovf, div_load;
  logic                       det_zero, last, res_neg;
  logic [BIT_NUM-1:0]         q_ext, res_c;

  function automatic logic signed [PW-1:0] sx(input logic signed [BIT_NUM-1:0] v);
    return {{(PW-BIT_NUM){v[BIT_NUM-1]}}, v};
  endfunction

  function automatic logic [PW-1:0] mag(input logic signed [PW-1:0] v);
    return v[PW-1] ? -v : v;
  endfunction

  always_comb begin
    det_c    = sx(a00) * sx(a11) - sx(a01) * sx(a10);
    n0_c     = sx(a11) * sx(c00) - sx(a01) * sx(c10);
    n1_c     = sx(a00) * sx(c10) - sx(a10) * sx(c00);
    n_sel    = (state == DIV1) ? n1 : n0;
    div_num  = {mag(n_sel), {FRAC_NUM{1'b0}}};
    div_den  = mag(det);
    det_zero = (det == '0);
    last     = (cnt == LAST);
    div_load = ((state == DIV0) || (state == DIV1)) && (cnt == '0) && !det_zero && !div_busy;
    q_mag    = div_ovf ? '1 : div_q;
    res_neg  = n_sel[PW-1] ^ det[PW-1];
    q_ext    = {1'b0, q_mag};
    res_c    = '0;
    if (!det_zero && div_done) res_c = res_neg ? -q_ext : q_ext;
  end

  assign in_ready  = (state == IDLE) || (state == DONE);
  assign out_valid = (state == DONE);

  fx_div_restoring #(
    .NUM_W_P(NW),
    .DEN_W  (PW),
    .Q_W    (Q_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .load       (div_load),
    .numerator  (div_num),
    .denominator(div_den),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_q),
    .overflow   (div_ovf)
  );

  // Singular operations still walk through both DIV states to keep latency fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a00      <= '0;
      a01      <= '0;
      a10      <= '0;
      a11      <= '0;
      c00      <= '0;
      c10      <= '0;
      det      <= '0;
      n0       <= '0;
      n1       <= '0;
      x0       <= '0;
      X_00     <= '0;
      X_10     <= '0;
      singular <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (in_valid) begin
            a00   <= A_00;
            a01   <= A_01;
            a10   <= A_10;
            a11   <= A_11;
            c00   <= C_00;
            c10   <= C_10;
            state <= PROD;
          end else begin
            state <= IDLE;
          end
        end
        PROD: begin
          det   <= det_c;
          n0    <= n0_c;
          n1    <= n1_c;
          cnt   <= '0;
          state <= DIV0;
        end
        DIV0: begin
          if (last) begin
            x0    <= res_c;
            cnt   <= '0;
            state <= DIV1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV1: begin
          if (last) begin
            X_00     <= x0;
            X_10     <= res_c;
            singular <= det_zero;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
